conv_stream_engine: RTL and testbench
=====================================

# conv_stream_engine

Parametrised K×K streaming convolution engine, successor to the fixed 3×3 convolve block. Accepts one K-pixel image column per handshake from the line buffers, maintains a K×K sliding window, and emits one shifted, clamped MAC result per window position at a configurable stride. It has a runtime-loadable signed kernel, valid/ready backpressure on both sides and a per-row end marker. It sits between the line-buffer stage and the pooling/activation stage of the NPU datapath.

## Interface
- `DATA_W`, 8: unsigned pixel width.
- `COEF_W`, 8: signed kernel coefficient width.
- `K`, 3: kernel edge (2..7).
- `ACC_W`, DATA_W+COEF_W+$clog2(K*K)+1: signed accumulator width.
- `OUT_W`, 8: unsigned result width.
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before output.
- `COL_W`, 10: width of the row-length field.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one row; sampled only in IDLE.
- `stride`  in  2  window step 1..3; 0 is treated as 1; latched at start.
- `cfg_cols`  in  COL_W  columns in the row; latched at start.
- `k_wr_en`  in  1  kernel write strobe.
- `k_wr_addr`  in  $clog2(K*K)  coefficient index, row-major.
- `k_wr_data`  in  COEF_W  signed coefficient.
- `col_valid`  in  1  input column valid.
- `col_ready`  out  1  input column accepted when high with col_valid.
- `col_data`  in  K*DATA_W  column; row 0 in the LSBs.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  OUT_W  result.
- `out_last`  out  1  marks the final result of the row.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at row completion.

## Operation
- States: IDLE, FILL, RUN, DRAIN, DONE.
- **IDLE**
  - `k_wr_en` writes the coefficient at `k_wr_addr`. Writes outside IDLE, and addresses ≥ K*K, are ignored.
  - `start` latches `stride` and `cfg_cols` and clears the column counter. Next state is FILL, or DONE if `cfg_cols < K`; the DONE path produces no outputs.
- **FILL**
  - Each accepted column shifts into the window; the newest column occupies window column K-1.
  - After K accepted columns, move to RUN.
- **RUN**
  - Accepted column index c (0-based) completes window position p = c-(K-1).
  - A result is issued when p mod stride == 0.
  - After `cfg_cols` accepted columns, move to DRAIN.
- **DRAIN**: wait until the pipeline is empty and the last result has been accepted, then move to DONE.
- **DONE**: `done` = 1 for one cycle, then IDLE.
- **Arithmetic**
  - sum = Σ pixel(unsigned) × coef(signed) over K*K taps, computed in ACC_W bits.
  - The sum is arithmetic-shifted right by SHIFT.
  - The result is reduced to OUT_W per Configuration.
- **Result count**: outputs per row = floor((cfg_cols-K)/stride)+1. `out_last` is set on the final one.
- **Handshake**
  - `out_valid`, `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
  - The whole pipeline stalls when `out_valid && !out_ready`.
  - `col_ready` = (state is FILL or RUN) && !stall.
- **`start` outside IDLE**: ignored.
- **Reset values**: all outputs 0; state IDLE; window, pipeline and all coefficients cleared to 0.
- **Reset mid-row**: takes effect immediately. Any partial output is discarded, and no `done` pulse follows.

## Timing
- The window updates on the accepting edge N.
- The product register loads at N+1.
- The sum/output register loads at N+2, so `out_valid` is high after edge N+2. Latency is 2 cycles with no stall.
- Throughput is one column per cycle with no backpressure.
- `done` is asserted the cycle after the last result handshake completes.
- `busy` falls in the same cycle that `done` falls.
- A `start` may be accepted the cycle after `done`.
- A kernel write is visible to a `start` sampled on the next edge.

## Configuration
- `CONV_STREAM_SAT_EN`
  - **Defined**: the shifted sum is clamped to [0, 2^OUT_W-1]; negatives become 0 and overflow becomes all ones.
  - **Undefined**: the low OUT_W bits of the shifted sum are output (wraps); no clamp logic is instantiated.

## Structure
- Package `conv_pkg`:
  - state enum `conv_state_t`;
  - default width/K localparams;
  - `sat_u` clamp function.
- Sub-module `conv_window`: K×K register array with shift enable, exposing the flattened window.
- Top level: FSM, counters, stride phase, kernel register file, product/sum pipeline, output register.

## Test plan
All scenarios use K=3 and SHIFT=0 unless stated.
- **Stride 1**: all-ones kernel, cfg_cols=5, column j carries every pixel = j+1 → outputs 18, 27, 36; out_last on 36; done pulse once.
- **Stride 2**: same kernel, cfg_cols=7, pixel = j+1 → outputs 18, 36, 54; out_last on 54.
- **Overflow**: all pixels 255, all-ones kernel → 255 with CONV_STREAM_SAT_EN; 247 without.
- **Negative clamp**: kernel all -1, pixels 10 → 0 with CONV_STREAM_SAT_EN; 166 (-90 mod 256) without.
- **Backpressure**: hold out_ready low 5 cycles mid-row → col_ready low during the stall, out_data stable, sequence identical to the no-stall run.
- **Reset mid-RUN, then degenerate row**: assert rst low mid-RUN → all outputs 0, kernel 0. Then run cfg_cols=2 → done pulse, zero outputs.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state type, default widths and the unsigned clamp helper for conv_stream_engine.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} conv_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_COL_W  = 10;
  localparam int SAT_W      = 64;

  // Clamp a signed value into the unsigned range [0, 2^out_w-1].
  function automatic logic [SAT_W-1:0] sat_u(input logic signed [SAT_W-1:0] v, input int out_w);
    logic signed [SAT_W-1:0] max_v;
    max_v = (64'sd1 <<< out_w) - 64'sd1;
    if (v < 0)
      return '0;
    else if (v > max_v)
      return max_v;
    else
      return v;
  endfunction

endpackage

// File: rtl/conv_window.sv
// KxK sliding pixel window: each shift moves every row left by one column and
// drops the incoming column into window column K-1. Flattened row-major, tap 0 in the LSBs.
module conv_window
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic [K*DATA_W-1:0]      col_data,
  output logic [K*K*DATA_W-1:0]    win_flat
);

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_row
      logic [K-1:0][DATA_W-1:0] row_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          row_reg <= '0;
        else if (shift_en)
          row_reg <= {col_data[gi*DATA_W +: DATA_W], row_reg[K-1:1]};
      end

      assign win_flat[gi*K*DATA_W +: K*DATA_W] = row_reg;
    end
  endgenerate

endmodule

// File: rtl/conv_stream_engine.sv
// Parametrised KxK streaming convolution: one column per handshake in, strided MAC results out.
// Define CONV_STREAM_SAT_EN to clamp results to [0, 2^OUT_W-1]; otherwise the low OUT_W bits wrap.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int K      = DEF_K,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(K*K) + 1,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = 0,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               stride,
  input  logic [COL_W-1:0]         cfg_cols,
  input  logic                     k_wr_en,
  input  logic [$clog2(K*K)-1:0]   k_wr_addr,
  input  logic signed [COEF_W-1:0] k_wr_data,
  input  logic                     col_valid,
  output logic                     col_ready,
  input  logic [K*DATA_W-1:0]      col_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int TAPS   = K*K;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int CNT_W  = COL_W + 2;

  conv_state_t state_reg, state_next;

  logic [1:0]             stride_reg, phase_reg;
  logic [COL_W-1:0]       cols_reg, col_cnt_reg;
  logic [TAPS*DATA_W-1:0] win_flat;
  logic [TAPS*PROD_W-1:0] prod_flat;
  logic                   issue_reg, issue_last_reg, p_valid_reg, p_last_reg;
  logic                   out_valid_reg, out_last_reg;
  logic [OUT_W-1:0]       out_data_reg;
  logic                   stall, accept, in_window, is_issue, is_last, row_end, drained;
  logic signed [ACC_W-1:0] sum_acc, acc_shift;
  logic [OUT_W-1:0]       result;

  // A held result freezes every stage, including column intake.
  assign stall     = out_valid_reg && !out_ready;
  assign col_ready = ((state_reg == FILL) || (state_reg == RUN)) && !stall;
  assign accept    = col_valid && col_ready;
  assign in_window = col_cnt_reg >= COL_W'(K-1);
  assign is_issue  = accept && in_window && (phase_reg == 2'd0);
  // No further issuing position fits once c + stride reaches the row length.
  assign is_last   = (CNT_W'(col_cnt_reg) + CNT_W'(stride_reg)) >= CNT_W'(cols_reg);
  assign row_end   = col_cnt_reg == (cols_reg - COL_W'(1));
  assign drained   = !issue_reg && !p_valid_reg && (!out_valid_reg || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_next = (cfg_cols < COL_W'(K)) ? DONE : FILL;
      end
      FILL: begin
        if (accept) begin
          if (row_end)
            state_next = DRAIN;
          else if (col_cnt_reg == COL_W'(K-1))
            state_next = RUN;
        end
      end
      RUN: begin
        if (accept && row_end)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (drained)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_reg  <= '0;
      cols_reg    <= '0;
      col_cnt_reg <= '0;
      phase_reg   <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stride_reg  <= (stride == 2'd0) ? 2'd1 : stride;
      cols_reg    <= cfg_cols;
      col_cnt_reg <= '0;
      phase_reg   <= '0;
    end else if (accept) begin
      col_cnt_reg <= col_cnt_reg + COL_W'(1);
      if (in_window)
        phase_reg <= (phase_reg == (stride_reg - 2'd1)) ? 2'd0 : (phase_reg + 2'd1);
    end
  end

  conv_window #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .col_data (col_data),
    .win_flat (win_flat)
  );

  // Per-tap coefficient register and product stage; out-of-range addresses match no tap.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [COEF_W-1:0] coef_reg;
      logic signed [PROD_W-1:0] prod_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          coef_reg <= '0;
        else if ((state_reg == IDLE) && k_wr_en && (k_wr_addr == ADDR_W'(gi)))
          coef_reg <= k_wr_data;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          prod_reg <= '0;
        else if (!stall)
          prod_reg <= $signed({1'b0, win_flat[gi*DATA_W +: DATA_W]}) * coef_reg;
      end

      assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
    end
  endgenerate

  always_comb begin
    sum_acc = '0;
    for (int i = 0; i < TAPS; i++)
      sum_acc = sum_acc + ACC_W'($signed(prod_flat[i*PROD_W +: PROD_W]));
  end

  assign acc_shift = sum_acc >>> SHIFT;

`ifdef CONV_STREAM_SAT_EN
  assign result = OUT_W'(sat_u(SAT_W'(acc_shift), OUT_W));
`else
  assign result = OUT_W'(acc_shift);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_reg      <= 1'b0;
      issue_last_reg <= 1'b0;
      p_valid_reg    <= 1'b0;
      p_last_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
    end else if (!stall) begin
      issue_reg      <= is_issue;
      issue_last_reg <= is_issue && is_last;
      p_valid_reg    <= issue_reg;
      p_last_reg     <= issue_last_reg;
      out_valid_reg  <= p_valid_reg;
      out_last_reg   <= p_last_reg;
      if (p_valid_reg)
        out_data_reg <= result;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed self-checking bench for conv_stream_engine (K=3, SHIFT=0).
module tb_conv_stream_engine;

  localparam int K = 3;

`ifdef CONV_STREAM_SAT_EN
  localparam logic [7:0] EXP_OVF = 8'd255;
  localparam logic [7:0] EXP_NEG = 8'd0;
`else
  localparam logic [7:0] EXP_OVF = 8'd247;
  localparam logic [7:0] EXP_NEG = 8'd166;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        stride = 2'd0;
  logic [9:0]        cfg_cols = 10'd0;
  logic              k_wr_en = 1'b0;
  logic [3:0]        k_wr_addr = 4'd0;
  logic signed [7:0] k_wr_data = 8'sd0;
  logic              col_valid = 1'b0;
  logic              col_ready;
  logic [23:0]       col_data = 24'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] got_data[$];
  logic       got_last[$];

  always #5 clk = ~clk;

  conv_stream_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stride    (stride),
    .cfg_cols  (cfg_cols),
    .k_wr_en   (k_wr_en),
    .k_wr_addr (k_wr_addr),
    .k_wr_data (k_wr_data),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Record every result handshake and every done pulse.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      $display("  result %0d: data=%0d last=%0b", got_data.size() - 1, out_data, out_last);
    end
    if (done)
      done_cnt++;
  end

  task automatic load_kernel(input int v);
    for (int i = 0; i < K*K; i++) begin
      @(posedge clk); #1;
      k_wr_en   = 1'b1;
      k_wr_addr = i[3:0];
      k_wr_data = v[7:0];
    end
    @(posedge clk); #1;
    k_wr_en = 1'b0;
  endtask

  // One row: start, stream columns (pixel = j+1 when inc, else pval), wait for done.
  task automatic drive_row(input int cols, input int strd, input bit inc, input int pval);
    int n;
    int v;
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    stride   = strd[1:0];
    cfg_cols = cols[9:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < cols && cols >= K; j++) begin
      v         = inc ? j + 1 : pval;
      col_data  = {3{v[7:0]}};
      col_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!col_ready && n < 200);
      if (!col_ready) begin
        errors++; checks++;
        $display("FAIL col_ready_timeout: col_ready=%0b required 1 at column %0d", col_ready, j);
        col_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL done_timeout: done=%0b required 1", done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
    checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready: got %0b required 0", col_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_stride1();
    logic [7:0] exp_d [3] = '{8'd18, 8'd27, 8'd36};
    logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] d;
    logic       l;
    load_kernel(1);
    drive_row(5, 1, 1'b1, 0);
    checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL s1_count: got %0d required 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 8'hxx;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL s1_data[%0d]: got %0d required %0d", i, d, exp_d[i]); end
      checks++; if (l !== exp_l[i]) begin errors++; $display("FAIL s1_last[%0d]: got %0b required %0b", i, l, exp_l[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL s1_done_pulses: got %0d required 1", done_cnt); end
    // stride 0 behaves as stride 1
    drive_row(5, 0, 1'b1, 0);
    checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL s0_count: got %0d required 3", got_data.size()); end
    d = (got_data.size() > 2) ? got_data[2] : 8'hxx;
    checks++; if (d !== 8'd36) begin errors++; $display("FAIL s0_data[2]: got %0d required 36", d); end
    $display("test_stride1: done");
  endtask

  task automatic test_stride2();
    logic [7:0] exp_d [3] = '{8'd18, 8'd36, 8'd54};
    logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] d;
    logic       l;
    drive_row(7, 2, 1'b1, 0);
    checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL s2_count: got %0d required 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 8'hxx;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL s2_data[%0d]: got %0d required %0d", i, d, exp_d[i]); end
      checks++; if (l !== exp_l[i]) begin errors++; $display("FAIL s2_last[%0d]: got %0b required %0b", i, l, exp_l[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL s2_done_pulses: got %0d required 1", done_cnt); end
    $display("test_stride2: done");
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    drive_row(3, 1, 1'b0, 255);
    d = (got_data.size() > 0) ? got_data[0] : 8'hxx;
    checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL ovf_count: got %0d required 1", got_data.size()); end
    checks++; if (d !== EXP_OVF) begin errors++; $display("FAIL ovf_data: got %0d required %0d", d, EXP_OVF); end
    $display("test_overflow: done");
  endtask

  task automatic test_negative();
    logic [7:0] d;
    load_kernel(-1);
    drive_row(3, 1, 1'b0, 10);
    d = (got_data.size() > 0) ? got_data[0] : 8'hxx;
    checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL neg_count: got %0d required 1", got_data.size()); end
    checks++; if (d !== EXP_NEG) begin errors++; $display("FAIL neg_data: got %0d required %0d", d, EXP_NEG); end
    $display("test_negative: done");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [5] = '{8'd18, 8'd27, 8'd36, 8'd45, 8'd54};
    logic [7:0] d;
    logic       l;
    load_kernel(1);
    fork
      drive_row(7, 1, 1'b1, 0);
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL bp_col_ready[%0d]: got %0b required 0", c, col_ready); end
          checks++; if (out_data !== 8'd27 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got data=%0d valid=%0b required data=27 valid=1", c, out_data, out_valid); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d required 5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d required %0d", i, d, exp_d[i]); end
    end
    l = (got_last.size() > 4) ? got_last[4] : 1'bx;
    checks++; if (l !== 1'b1) begin errors++; $display("FAIL bp_last: got %0b required 1", l); end
    $display("test_backpressure: done");
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d;
    done_cnt = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    stride   = 2'd1;
    cfg_cols = 10'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      col_data  = {3{8'(j + 1)}};
      col_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0b required 1", busy); end
    rst       = 1'b0;
    col_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL mid_out_data: got %0d required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_out_last: got %0b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b required 0", busy); end
    checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL mid_col_ready: got %0b required 0", col_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d required 0", done_cnt); end
    // kernel was cleared, so a full window of non-zero pixels yields 0
    drive_row(3, 1, 1'b0, 5);
    d = (got_data.size() > 0) ? got_data[0] : 8'hxx;
    checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL mid_kernel_count: got %0d required 1", got_data.size()); end
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL mid_kernel_zero: got %0d required 0", d); end
    drive_row(2, 1, 1'b1, 0);
    checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL degen_count: got %0d required 0", got_data.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL degen_done: got %0d required 1", done_cnt); end
    $display("test_reset_mid_run: done");
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_overflow();
    test_negative();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
